// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
// Holds CP0 exception codes, default field widths, the reset PC and the
// per-cycle update selector used by pipe_stage_reg.
package pipe_pkg;

  // CP0 ExcCode values used across the pipeline (0 doubles as "no exception")
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Default field widths
  localparam int TW_DEF  = 3;
  localparam int ECW_DEF = 5;

  // PC value seen by the stage after reset or kill
  localparam logic [31:0] PC_RST_DEF = 32'h0000_3000;

  // Which kind of update a stage register performs on the next edge
  typedef enum logic [2:0] {
    UPD_RESET  = 3'd0,
    UPD_KILL   = 3'd1,
    UPD_HOLD   = 3'd2,
    UPD_BUBBLE = 3'd3,
    UPD_LOAD   = 3'd4
  } upd_e;

endpackage

// File: rtl/exc_merge.sv
// Oldest-wins exception merge for one pipeline boundary.
// An exception already travelling down the pipe (exc) is older than one
// detected in the stage feeding this register (local_exc), so it takes
// priority. Slots without a real instruction never carry an exception.
// Ports:
//   exc       in  ECW  upstream exception code (0 = none)
//   local_exc in  ECW  exception raised by the feeding stage this cycle
//   valid     in  1    slot holds a real instruction
//   merged    out ECW  code to be registered
module exc_merge #(
  parameter int ECW = pipe_pkg::ECW_DEF
) (
  input  logic [ECW-1:0] exc,
  input  logic [ECW-1:0] local_exc,
  input  logic           valid,
  output logic [ECW-1:0] merged
);

  // Priority select: invalid slot -> none, then upstream, then local
  always_comb begin
    merged = '0;
    if (!valid) begin
      merged = '0;
    end else if (exc != '0) begin
      merged = exc;
    end else begin
      merged = local_exc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register for the D/E, E/M and M/W boundaries.
// Carries instr, PC, NDATA payload words, Tnew, a merged exception code and
// the branch-delay flag. Supports stall (hold), bubble insertion and
// exception kill; counts consecutive hold cycles for debug.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   hold_i/bubble_i/kill_i control (priority kill > hold > bubble > load)
//   valid_i, instr_i, pc_i, data_i, tnew_i, exc_i, local_exc_i, bd_i
//                         upstream slot contents
//   valid_o .. bd_o       registered slot contents
//   hold_cnt_o            consecutive hold cycles, saturating
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int             DW       = 32,
  parameter int             NDATA    = 4,
  parameter int             TW       = TW_DEF,
  parameter int             ECW      = ECW_DEF,
  parameter bit             TNEW_DEC = 1'b1,
  parameter logic [DW-1:0]  PC_RST   = DW'(PC_RST_DEF),
  parameter int             HCW      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold_i,
  input  logic                bubble_i,
  input  logic                kill_i,
  input  logic                valid_i,
  input  logic [DW-1:0]       instr_i,
  input  logic [DW-1:0]       pc_i,
  input  logic [NDATA*DW-1:0] data_i,
  input  logic [TW-1:0]       tnew_i,
  input  logic [ECW-1:0]      exc_i,
  input  logic [ECW-1:0]      local_exc_i,
  input  logic                bd_i,
  output logic                valid_o,
  output logic [DW-1:0]       instr_o,
  output logic [DW-1:0]       pc_o,
  output logic [NDATA*DW-1:0] data_o,
  output logic [TW-1:0]       tnew_o,
  output logic [ECW-1:0]      exc_o,
  output logic                bd_o,
  output logic [HCW-1:0]      hold_cnt_o
);

  upd_e          op;
  logic [ECW-1:0] exc_next;
  logic [TW-1:0]  tnew_next;

  exc_merge #(.ECW(ECW)) u_exc_merge (
    .exc       (exc_i),
    .local_exc (local_exc_i),
    .valid     (valid_i),
    .merged    (exc_next)
  );

  // Decode the update kind; kill beats hold so an exception flush is never stalled
  always_comb begin
    op = UPD_LOAD;
    if (reset) begin
      op = UPD_RESET;
    end else if (kill_i) begin
      op = UPD_KILL;
    end else if (hold_i) begin
      op = UPD_HOLD;
    end else if (bubble_i) begin
      op = UPD_BUBBLE;
    end else begin
      op = UPD_LOAD;
    end
  end

  // Tnew for the next stage: one cycle closer to ready, never below zero
  always_comb begin
    tnew_next = tnew_i;
    if (!TNEW_DEC) begin
      tnew_next = tnew_i;
    end else if (tnew_i == '0) begin
      tnew_next = '0;
    end else begin
      tnew_next = tnew_i - TW'(1);
    end
  end

  // Slot fields; a bubble keeps PC/BD so CP0 still gets a correct EPC
  always_ff @(posedge clk) begin
    case (op)
      UPD_HOLD: begin
        valid_o <= valid_o;
        instr_o <= instr_o;
        pc_o    <= pc_o;
        data_o  <= data_o;
        tnew_o  <= tnew_o;
        exc_o   <= exc_o;
        bd_o    <= bd_o;
      end
      UPD_BUBBLE: begin
        valid_o <= 1'b0;
        instr_o <= '0;
        pc_o    <= pc_i;
        data_o  <= '0;
        tnew_o  <= '0;
        exc_o   <= '0;
        bd_o    <= bd_i;
      end
      UPD_LOAD: begin
        valid_o <= valid_i;
        instr_o <= instr_i;
        pc_o    <= pc_i;
        data_o  <= data_i;
        tnew_o  <= tnew_next;
        exc_o   <= exc_next;
        bd_o    <= bd_i;
      end
      default: begin
        valid_o <= 1'b0;
        instr_o <= '0;
        pc_o    <= PC_RST;
        data_o  <= '0;
        tnew_o  <= '0;
        exc_o   <= '0;
        bd_o    <= 1'b0;
      end
    endcase
  end

  // Consecutive-hold counter; any non-hold update restarts it
  always_ff @(posedge clk) begin
    if (op == UPD_HOLD) begin
      if (hold_cnt_o != '1) begin
        hold_cnt_o <= hold_cnt_o + HCW'(1);
      end else begin
        hold_cnt_o <= hold_cnt_o;
      end
    end else begin
      hold_cnt_o <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a default instance (TNEW_DEC=1,
// NDATA=4) and a pass-through instance (TNEW_DEC=0, NDATA=2) share stimulus.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset, hold, bubble, kill, valid, bd;
  logic [31:0]  instr, pc;
  logic [127:0] data;
  logic [2:0]   tnew;
  logic [4:0]   exc, lexc;

  logic         a_valid, a_bd, b_valid, b_bd;
  logic [31:0]  a_instr, a_pc, b_instr, b_pc;
  logic [127:0] a_data;
  logic [63:0]  b_data;
  logic [2:0]   a_tnew, b_tnew;
  logic [4:0]   a_exc, b_exc;
  logic [7:0]   a_hc, b_hc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_a (
    .clk(clk), .reset(reset), .hold_i(hold), .bubble_i(bubble), .kill_i(kill),
    .valid_i(valid), .instr_i(instr), .pc_i(pc), .data_i(data), .tnew_i(tnew),
    .exc_i(exc), .local_exc_i(lexc), .bd_i(bd),
    .valid_o(a_valid), .instr_o(a_instr), .pc_o(a_pc), .data_o(a_data),
    .tnew_o(a_tnew), .exc_o(a_exc), .bd_o(a_bd), .hold_cnt_o(a_hc)
  );

  pipe_stage_reg #(.TNEW_DEC(1'b0), .NDATA(2)) u_b (
    .clk(clk), .reset(reset), .hold_i(hold), .bubble_i(bubble), .kill_i(kill),
    .valid_i(valid), .instr_i(instr), .pc_i(pc), .data_i(data[63:0]), .tnew_i(tnew),
    .exc_i(exc), .local_exc_i(lexc), .bd_i(bd),
    .valid_o(b_valid), .instr_o(b_instr), .pc_o(b_pc), .data_o(b_data),
    .tnew_o(b_tnew), .exc_o(b_exc), .bd_o(b_bd), .hold_cnt_o(b_hc)
  );

  typedef struct {
    logic rst, kil, hld, bub, vld;
    logic [31:0] instr, pc; logic [127:0] data;
    logic [2:0] tnew; logic [4:0] exc, lexc; logic bd;
    logic e_vld; logic [31:0] e_instr, e_pc; logic [127:0] e_data;
    logic [2:0] e_tnew, e_tnew_b; logic [4:0] e_exc; logic e_bd; logic [7:0] e_hc;
  } vec_t;

  localparam logic [127:0] D1 = 128'h0101_0202_0303_0404_0505_0606_0707_0808;
  localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D3 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  localparam logic [127:0] D4 = 128'hFFFF_0000_FFFF_0000_A5A5_5A5A_0F0F_F0F0;
  localparam logic [127:0] D5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] D6 = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
  localparam logic [127:0] D7 = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
  localparam logic [127:0] D8 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] Z  = 128'h0;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, k, h, bb, v, input logic [31:0] ins, p,
                       input logic [127:0] d, input logic [2:0] t,
                       input logic [4:0] e, le, input logic b);
    reset = r; kill = k; hold = h; bubble = bb; valid = v;
    instr = ins; pc = p; data = d; tnew = t; exc = e; lexc = le; bd = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full state snapshots used to prove outputs stay frozen during holds
  function automatic logic [255:0] snap_a();
    return 256'({a_valid, a_instr, a_pc, a_data, a_tnew, a_exc, a_bd});
  endfunction
  function automatic logic [255:0] snap_b();
    return 256'({b_valid, b_instr, b_pc, b_data, b_tnew, b_exc, b_bd});
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_a_valid"}, 256'(a_valid), 256'(1'b0));
    check({tag, "_a_instr"}, 256'(a_instr), 256'(32'h0));
    check({tag, "_a_pc"},    256'(a_pc),    256'(32'h0000_3000));
    check({tag, "_a_data"},  256'(a_data),  256'(128'h0));
    check({tag, "_a_tnew"},  256'(a_tnew),  256'(3'd0));
    check({tag, "_a_exc"},   256'(a_exc),   256'(5'd0));
    check({tag, "_a_bd"},    256'(a_bd),    256'(1'b0));
    check({tag, "_a_hc"},    256'(a_hc),    256'(8'd0));
    check({tag, "_b_pc"},    256'(b_pc),    256'(32'h0000_3000));
    check({tag, "_b_hc"},    256'(b_hc),    256'(8'd0));
  endtask

  initial begin
    logic [255:0] sa, sb;
    int exp_hc;

    // rst kil hld bub vld instr pc data tnew exc lexc bd | e_vld e_instr e_pc e_data e_tnew e_tnew_b e_exc e_bd e_hc
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 32'hAAAA_0001, 32'h3004, D1, 3'd2, 5'd0, 5'd12, 1'b1,
                 1'b0, 32'h0, 32'h3000, Z, 3'd0, 3'd0, 5'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'hAAAA_0001, 32'h3004, D1, 3'd2, 5'd0, 5'd12, 1'b0,
                 1'b1, 32'hAAAA_0001, 32'h3004, D1, 3'd1, 3'd2, 5'd12, 1'b0, 8'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'hAAAA_0002, 32'h3008, D2, 3'd3, 5'd4, 5'd12, 1'b0,
                 1'b1, 32'hAAAA_0002, 32'h3008, D2, 3'd2, 3'd3, 5'd4, 1'b0, 8'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'hAAAA_0003, 32'h300C, D3, 3'd0, 5'd0, 5'd0, 1'b1,
                 1'b1, 32'hAAAA_0003, 32'h300C, D3, 3'd0, 3'd0, 5'd0, 1'b1, 8'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'hAAAA_0004, 32'h3010, D4, 3'd5, 5'd5, 5'd10, 1'b0,
                 1'b0, 32'hAAAA_0004, 32'h3010, D4, 3'd4, 3'd5, 5'd0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 32'hAAAA_0005, 32'h3010, D5, 3'd6, 5'd4, 5'd12, 1'b1,
                 1'b0, 32'h0, 32'h3010, Z, 3'd0, 3'd0, 5'd0, 1'b1, 8'd0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'hAAAA_0006, 32'h3014, D6, 3'd7, 5'd0, 5'd0, 1'b0,
                 1'b1, 32'hAAAA_0006, 32'h3014, D6, 3'd6, 3'd7, 5'd0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b1, 32'hAAAA_0007, 32'h3018, D7, 3'd1, 5'd12, 5'd12, 1'b1,
                 1'b1, 32'hAAAA_0006, 32'h3014, D6, 3'd6, 3'd7, 5'd0, 1'b0, 8'd1};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 32'hAAAA_0007, 32'h301C, D7, 3'd1, 5'd0, 5'd0, 1'b1,
                 1'b1, 32'hAAAA_0006, 32'h3014, D6, 3'd6, 3'd7, 5'd0, 1'b0, 8'd2};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 32'hAAAA_0007, 32'h3020, D7, 3'd1, 5'd0, 5'd0, 1'b1,
                 1'b0, 32'h0, 32'h3000, Z, 3'd0, 3'd0, 5'd0, 1'b0, 8'd0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'hAAAA_0008, 32'h3024, D8, 3'd1, 5'd0, 5'd12, 1'b0,
                 1'b1, 32'hAAAA_0008, 32'h3024, D8, 3'd0, 3'd1, 5'd12, 1'b0, 8'd0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 32'hAAAA_0008, 32'h3028, D8, 3'd4, 5'd0, 5'd0, 1'b1,
                 1'b0, 32'h0, 32'h3000, Z, 3'd0, 3'd0, 5'd0, 1'b0, 8'd0};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, Z, 3'd0, 5'd0, 5'd0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].kil, vecs[i].hld, vecs[i].bub, vecs[i].vld,
            vecs[i].instr, vecs[i].pc, vecs[i].data, vecs[i].tnew,
            vecs[i].exc, vecs[i].lexc, vecs[i].bd);
      tick();
      check($sformatf("v%0d_valid", i),  256'(a_valid), 256'(vecs[i].e_vld));
      check($sformatf("v%0d_instr", i),  256'(a_instr), 256'(vecs[i].e_instr));
      check($sformatf("v%0d_pc", i),     256'(a_pc),    256'(vecs[i].e_pc));
      check($sformatf("v%0d_data", i),   256'(a_data),  256'(vecs[i].e_data));
      check($sformatf("v%0d_tnew", i),   256'(a_tnew),  256'(vecs[i].e_tnew));
      check($sformatf("v%0d_exc", i),    256'(a_exc),   256'(vecs[i].e_exc));
      check($sformatf("v%0d_bd", i),     256'(a_bd),    256'(vecs[i].e_bd));
      check($sformatf("v%0d_hc", i),     256'(a_hc),    256'(vecs[i].e_hc));
      check($sformatf("v%0d_b_tnew", i), 256'(b_tnew),  256'(vecs[i].e_tnew_b));
      check($sformatf("v%0d_b_data", i), 256'(b_data),  256'(vecs[i].e_data[63:0]));
      check($sformatf("v%0d_b_exc", i),  256'(b_exc),   256'(vecs[i].e_exc));
      check($sformatf("v%0d_b_hc", i),   256'(b_hc),    256'(vecs[i].e_hc));
    end

    // Long hold: outputs frozen under changing inputs, counter saturates at 255
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0001, 32'h3040, D3, 3'd4, 5'd0, 5'd10, 1'b1);
    tick();
    check("pre_hold_a_tnew", 256'(a_tnew), 256'(3'd3));
    check("pre_hold_b_tnew", 256'(b_tnew), 256'(3'd4));
    check("pre_hold_exc",    256'(a_exc),  256'(5'd10));
    sa = snap_a();
    sb = snap_b();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b0, 1'b1, i[0], 1'b1, $urandom, $urandom,
            {$urandom, $urandom, $urandom, $urandom}, 3'($urandom), 5'($urandom),
            5'($urandom), 1'($urandom));
      tick();
      exp_hc = (i + 1 > 255) ? 255 : i + 1;
      check($sformatf("hold%0d_a", i),  snap_a(),       sa);
      check($sformatf("hold%0d_b", i),  snap_b(),       sb);
      check($sformatf("hold%0d_hc", i), 256'(a_hc),     256'(exp_hc));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 32'h3044, D4, 3'd7, 5'd0, 5'd0, 1'b0);
    tick();
    check("after_hold_hc",   256'(a_hc),    256'(8'd0));
    check("after_hold_b_hc", 256'(b_hc),    256'(8'd0));
    check("after_hold_pc",   256'(a_pc),    256'(32'h3044));
    check("after_hold_tnew", 256'(a_tnew),  256'(3'd6));
    check("after_hold_b_tn", 256'(b_tnew),  256'(3'd7));

    // Reset arriving in the middle of a hold run
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCCCC_0000, 32'h3050, D5, 3'd2, 5'd0, 5'd0, 1'b1);
      tick();
    end
    check("mid_hold_hc", 256'(a_hc), 256'(8'd10));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCCCC_0000, 32'h3050, D5, 3'd2, 5'd4, 5'd0, 1'b1);
    tick();
    check_reset_state("rst_in_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
